// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: FSM states and BCD time limits.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETHOUR = 3'd1,
        SETMIN  = 3'd2,
        RING    = 3'd3,
        SNZ     = 3'd4
    } state_t;

    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;

    // Digit-level forms of the limits, as held in the BCD registers.
    localparam logic [1:0] HOUR_MAX_10 = 2'(HOUR_MAX / 10);
    localparam logic [3:0] HOUR_MAX_1  = 4'(HOUR_MAX % 10);
    localparam logic [2:0] MIN_MAX_10  = 3'(MIN_MAX / 10);
    localparam logic [3:0] MIN_MAX_1   = 4'(MIN_MAX % 10);

endpackage

// File: rtl/alm_time_reg.sv
// Alarm time register: four BCD digits with independent hour/minute increment.
module alm_time_reg
    import alarm_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       inc_hour,
    input  logic       inc_min,
    output logic [3:0] min1,
    output logic [2:0] min10,
    output logic [3:0] hour1,
    output logic [1:0] hour10
);

    // Hour wraps 23 -> 00, minute wraps 59 -> 00; the fields never carry into each other.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hour10 <= '0;
            hour1  <= '0;
            min10  <= '0;
            min1   <= '0;
        end else begin
            if (inc_hour) begin
                if (hour10 == HOUR_MAX_10 && hour1 == HOUR_MAX_1) begin
                    hour10 <= '0;
                    hour1  <= '0;
                end else if (hour1 == 4'd9) begin
                    hour1  <= '0;
                    hour10 <= hour10 + 2'd1;
                end else begin
                    hour1  <= hour1 + 4'd1;
                end
            end
            if (inc_min) begin
                if (min1 == MIN_MAX_1) begin
                    min1 <= '0;
                    if (min10 == MIN_MAX_10) begin
                        min10 <= '0;
                    end else begin
                        min10 <= min10 + 3'd1;
                    end
                end else begin
                    min1 <= min1 + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm-time setting, arming, ring/snooze sequencing and display enables.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned CNT_W      = 9
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SIG1HZ,
    input  logic       SIG2HZ,
    input  logic [3:0] MIN1,
    input  logic [2:0] MIN10,
    input  logic [3:0] HOUR1,
    input  logic [1:0] HOUR10,
    input  logic       ALMMODE,
    input  logic       SELECT,
    input  logic       ADJUST,
    input  logic       ALMSW,
    input  logic       STOP,
    input  logic       SNOOZE,
    output logic [3:0] AMIN1,
    output logic [2:0] AMIN10,
    output logic [3:0] AHOUR1,
    output logic [1:0] AHOUR10,
    output logic       ALMEN,
    output logic       AMINON,
    output logic       AHOURON,
    output logic       BEEP,
    output logic       ALMSET
);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               almen_d;
    logic               match, match_q;
    logic               trigger;
    logic               inc_hour, inc_min;

    alm_time_reg u_time (
        .CLK      (CLK),
        .RST      (RST),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .min1     (AMIN1),
        .min10    (AMIN10),
        .hour1    (AHOUR1),
        .hour10   (AHOUR10)
    );

    assign match   = (AMIN1 == MIN1) && (AMIN10 == MIN10) &&
                     (AHOUR1 == HOUR1) && (AHOUR10 == HOUR10);
    // Rising edge of match only, so a stopped alarm stays quiet for the rest of that minute.
    assign trigger = ALMEN && match && !match_q;

    // State, shared tick counter, enable flag and match history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            ALMEN   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            ALMEN   <= almen_d;
            match_q <= match;
        end
    end

    // Next state, counter, enable and field increments.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        almen_d  = ALMEN;
        inc_hour = 1'b0;
        inc_min  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ALMSW) almen_d = !ALMEN;
                if (ALMMODE) begin
                    state_d = SETHOUR;
                end else if (trigger) begin
                    state_d = RING;
                    cnt_d   = '0;
                end
            end
            SETHOUR, SETMIN: begin
                if (ALMSW) almen_d = !ALMEN;
                // Increment uses the field selected before any SELECT toggle this cycle.
                inc_hour = ADJUST && (state == SETHOUR);
                inc_min  = ADJUST && (state == SETMIN);
                if (ALMMODE) begin
                    state_d = IDLE;
                end else if (SELECT) begin
                    state_d = (state == SETHOUR) ? SETMIN : SETHOUR;
                end
            end
            RING: begin
                if (STOP) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ALMSW) begin
                    state_d = IDLE;
                    almen_d = 1'b0;
                    cnt_d   = '0;
                end else if (SNOOZE) begin
                    state_d = SNZ;
                    cnt_d   = '0;
                end else if (SIG1HZ) begin
                    if (cnt == CNT_W'(RING_SEC - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            SNZ: begin
                if (STOP || ALMSW) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (ALMSW) almen_d = 1'b0;
                end else if (SIG1HZ) begin
                    if (cnt == CNT_W'(SNOOZE_SEC - 1)) begin
                        state_d = RING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Display and buzzer outputs decoded from the registered state.
    always_comb begin
        BEEP    = (state == RING) && SIG2HZ;
        ALMSET  = (state == SETHOUR) || (state == SETMIN);
        AHOURON = !((state == SETHOUR) && SIG2HZ);
        AMINON  = !((state == SETMIN) && SIG2HZ);
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_alarm_ctrl;

    localparam int RING_T   = 60;
    localparam int SNOOZE_T = 300;

    localparam bit [5:0] P_MODE = 6'b100000;
    localparam bit [5:0] P_SEL  = 6'b010000;
    localparam bit [5:0] P_ADJ  = 6'b001000;
    localparam bit [5:0] P_SW   = 6'b000100;
    localparam bit [5:0] P_STOP = 6'b000010;
    localparam bit [5:0] P_SNZ  = 6'b000001;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SIG1HZ = 1'b0;
    logic       SIG2HZ = 1'b0;
    logic [3:0] MIN1 = '0;
    logic [2:0] MIN10 = '0;
    logic [3:0] HOUR1 = '0;
    logic [1:0] HOUR10 = '0;
    logic       ALMMODE = 1'b0, SELECT = 1'b0, ADJUST = 1'b0;
    logic       ALMSW = 1'b0, STOP = 1'b0, SNOOZE = 1'b0;
    logic [3:0] AMIN1;
    logic [2:0] AMIN10;
    logic [3:0] AHOUR1;
    logic [1:0] AHOUR10;
    logic       ALMEN, AMINON, AHOURON, BEEP, ALMSET;

    int checks = 0;
    int passes = 0;

    // Behavioural model: alarm time as plain integers, activity as flags, ticks seen so far.
    int ah = 0, am = 0, secs = 0;
    bit armed = 0, set_h = 0, set_m = 0, ringing = 0, snoozing = 0, prev_match = 0;
    int th, tm;
    bit now_match, fire;

    alarm_ctrl #(.RING_SEC(RING_T), .SNOOZE_SEC(SNOOZE_T), .CNT_W(9)) dut (
        .CLK(CLK), .RST(RST), .SIG1HZ(SIG1HZ), .SIG2HZ(SIG2HZ),
        .MIN1(MIN1), .MIN10(MIN10), .HOUR1(HOUR1), .HOUR10(HOUR10),
        .ALMMODE(ALMMODE), .SELECT(SELECT), .ADJUST(ADJUST),
        .ALMSW(ALMSW), .STOP(STOP), .SNOOZE(SNOOZE),
        .AMIN1(AMIN1), .AMIN10(AMIN10), .AHOUR1(AHOUR1), .AHOUR10(AHOUR10),
        .ALMEN(ALMEN), .AMINON(AMINON), .AHOURON(AHOURON), .BEEP(BEEP), .ALMSET(ALMSET)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        repeat (3) @(posedge CLK);
        #2 SIG2HZ = ~SIG2HZ;
    end

    // Model update on every clock edge using the inputs the DUT samples.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ah = 0; am = 0; secs = 0;
            armed = 0; set_h = 0; set_m = 0; ringing = 0; snoozing = 0; prev_match = 0;
        end else begin
            th = HOUR10 * 10 + HOUR1;
            tm = MIN10 * 10 + MIN1;
            now_match = (ah == th) && (am == tm);
            if (ringing) begin
                if (STOP) ringing = 0;
                else if (ALMSW) begin ringing = 0; armed = 0; end
                else if (SNOOZE) begin ringing = 0; snoozing = 1; secs = 0; end
                else if (SIG1HZ) begin
                    secs++;
                    if (secs == RING_T) ringing = 0;
                end
            end else if (snoozing) begin
                if (STOP || ALMSW) begin
                    snoozing = 0;
                    if (ALMSW) armed = 0;
                end else if (SIG1HZ) begin
                    secs++;
                    if (secs == SNOOZE_T) begin snoozing = 0; ringing = 1; secs = 0; end
                end
            end else if (set_h || set_m) begin
                if (ADJUST) begin
                    if (set_h) ah = (ah + 1) % 24;
                    else       am = (am + 1) % 60;
                end
                if (ALMSW) armed = !armed;
                if (ALMMODE) begin set_h = 0; set_m = 0; end
                else if (SELECT) begin set_h = !set_h; set_m = !set_m; end
            end else begin
                fire = armed && now_match && !prev_match;
                if (ALMSW) armed = !armed;
                if (ALMMODE) set_h = 1;
                else if (fire) begin ringing = 1; secs = 0; end
            end
            prev_match = now_match;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge CLK) begin
        logic [17:0] exp_v, act_v;
        exp_v = {2'(ah / 10), 4'(ah % 10), 3'(am / 10), 4'(am % 10), armed,
                 !(set_m && SIG2HZ), !(set_h && SIG2HZ), ringing && SIG2HZ, set_h || set_m};
        act_v = {AHOUR10, AHOUR1, AMIN10, AMIN1, ALMEN, AMINON, AHOURON, BEEP, ALMSET};
        checks++;
        if (act_v === exp_v) passes++;
        else $display("FAIL cycle_compare t=%0t actual=%h expected=%h", $time, act_v, exp_v);
    end

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic press(input bit [5:0] p);
        {ALMMODE, SELECT, ADJUST, ALMSW, STOP, SNOOZE} = p;
        cyc(1);
        {ALMMODE, SELECT, ADJUST, ALMSW, STOP, SNOOZE} = '0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            SIG1HZ = 1'b1;
            cyc(1);
            SIG1HZ = 1'b0;
            cyc(1);
        end
    endtask

    task automatic set_time(input int h, input int m);
        HOUR10 = 2'(h / 10);
        HOUR1  = 4'(h % 10);
        MIN10  = 3'(m / 10);
        MIN1   = 4'(m % 10);
    endtask

    // Leaves the bench just after a clock edge with SIG2HZ high (bounded wait).
    task automatic blink_high();
        int k = 0;
        #1;
        while (!SIG2HZ && k < 20) begin
            cyc(1);
            #1;
            k++;
        end
        if (!SIG2HZ) begin
            checks++;
            $display("FAIL blink_timeout actual=%0b required=1", SIG2HZ);
        end
    endtask

    // Makes the current time re-enter 07:30 so the match rises.
    task automatic retrigger();
        set_time(7, 31);
        cyc(2);
        set_time(7, 30);
        cyc(2);
    endtask

    initial begin
        cyc(2);
        #1;
        lit("reset_beep", 8'(BEEP), 8'd0);
        lit("reset_almset", 8'(ALMSET), 8'd0);
        lit("reset_enables", {6'd0, AMINON, AHOURON}, 8'h03);
        lit("reset_almen", 8'(ALMEN), 8'd0);
        lit("reset_alarm", {AHOUR10, AHOUR1, 2'b00}, 8'h00);
        RST = 1'b0;
        set_time(12, 34);
        cyc(2);

        // 1: hour wrap, minute wrap, blink in the selected field only
        press(P_MODE);
        repeat (25) press(P_ADJ);
        #1;
        lit("hour_after_25", {2'b00, AHOUR10, AHOUR1}, 8'h01);
        lit("model_hour_25", 8'(ah), 8'd1);
        blink_high();
        lit("sethour_blink", {6'd0, AMINON, AHOURON}, 8'h02);
        press(P_SEL);
        repeat (61) press(P_ADJ);
        #1;
        lit("min_after_61", {1'b0, AMIN10, AMIN1}, 8'h01);
        lit("model_min_61", 8'(am), 8'd1);
        blink_high();
        lit("setmin_blink", {6'd0, AMINON, AHOURON}, 8'h01);
        press(P_MODE);
        #1;
        lit("leave_set", 8'(ALMSET), 8'd0);

        // 2: alarm 07:30, armed, ring lasts exactly RING_T ticks, no re-trigger
        press(P_MODE);
        repeat (5) press(P_ADJ);
        press(P_ADJ | P_SEL);
        #1;
        lit("adj_sel_hour", {2'b00, AHOUR10, AHOUR1}, 8'h07);
        blink_high();
        lit("adj_sel_to_min", {6'd0, AMINON, AHOURON}, 8'h01);
        repeat (29) press(P_ADJ);
        #1;
        lit("alarm_min_30", {1'b0, AMIN10, AMIN1}, 8'h30);
        press(P_MODE);
        press(P_SW);
        #1;
        lit("armed", 8'(ALMEN), 8'd1);
        set_time(7, 29);
        cyc(2);
        set_time(7, 30);
        cyc(1);
        blink_high();
        lit("ring_beep", 8'(BEEP), 8'd1);
        ticks(RING_T - 1);
        blink_high();
        lit("ring_before_last", 8'(BEEP), 8'd1);
        ticks(1);
        blink_high();
        lit("ring_auto_stop", 8'(BEEP), 8'd0);
        cyc(20);

        // 3: snooze then re-ring, STOP keeps the alarm armed
        retrigger();
        press(P_SNZ);
        blink_high();
        lit("snooze_quiet", 8'(BEEP), 8'd0);
        ticks(SNOOZE_T - 1);
        blink_high();
        lit("snooze_before_last", 8'(BEEP), 8'd0);
        ticks(1);
        blink_high();
        lit("snooze_rering", 8'(BEEP), 8'd1);
        press(P_STOP);
        #1;
        lit("stop_keeps_armed", 8'(ALMEN), 8'd1);
        blink_high();
        lit("stop_quiet", 8'(BEEP), 8'd0);

        // 4: STOP beats SNOOZE; ALMSW in snooze disarms
        retrigger();
        press(P_STOP | P_SNZ);
        blink_high();
        lit("stop_wins", 8'(BEEP), 8'd0);
        ticks(SNOOZE_T + 2);
        blink_high();
        lit("no_late_rering", 8'(BEEP), 8'd0);
        retrigger();
        press(P_SNZ);
        ticks(3);
        press(P_SW);
        #1;
        lit("snz_almsw_disarm", 8'(ALMEN), 8'd0);

        // 5: disarmed alarm stays quiet; ALMMODE beats a rising match
        retrigger();
        blink_high();
        lit("disarmed_quiet", 8'(BEEP), 8'd0);
        press(P_SW);
        set_time(7, 31);
        cyc(2);
        set_time(7, 30);
        press(P_MODE);
        #1;
        lit("mode_beats_match", 8'(ALMSET), 8'd1);
        cyc(3);
        press(P_MODE);
        cyc(5);
        blink_high();
        lit("no_ring_after_set", 8'(BEEP), 8'd0);

        // 6: asynchronous reset in the middle of a ring
        retrigger();
        blink_high();
        lit("ring_before_rst", 8'(BEEP), 8'd1);
        RST = 1'b1;
        #1;
        lit("rst_beep", 8'(BEEP), 8'd0);
        lit("rst_alarm", {AHOUR10, AHOUR1, 2'b00}, 8'h00);
        lit("rst_alarm_min", {1'b0, AMIN10, AMIN1}, 8'h00);
        lit("rst_almen", 8'(ALMEN), 8'd0);
        cyc(2);
        RST = 1'b0;
        cyc(6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm controller for the 24-hour clock: holds alarm time (BCD hh:mm) and sequences set, armed, ringing and snooze.
- Sits beside the main mode controller; consumes current-time digits from the time counters, shares MODE/SELECT/ADJUST-style one-cycle button pulses, drives buzzer and blink enables for the alarm display.

Parameters:
- RING_SEC, 60, number of 1 Hz ticks a ring lasts before auto-stop.
- SNOOZE_SEC, 300, number of 1 Hz ticks in snooze before re-ring.
- CNT_W, 9, width of the shared tick counter; must hold max(RING_SEC, SNOOZE_SEC).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- SIG1HZ  in  1  one-CLK pulse at 1 Hz.
- SIG2HZ  in  1  2 Hz square wave, used for blink and beep.
- MIN1  in  4  current minute units, BCD.
- MIN10  in  3  current minute tens, BCD.
- HOUR1  in  4  current hour units, BCD.
- HOUR10  in  2  current hour tens, BCD.
- ALMMODE  in  1  pulse; enter or leave alarm-set mode.
- SELECT  in  1  pulse; toggle hour/minute field while setting.
- ADJUST  in  1  pulse; increment selected field.
- ALMSW  in  1  pulse; toggle alarm enable.
- STOP  in  1  pulse; stop ringing or cancel snooze.
- SNOOZE  in  1  pulse; snooze while ringing.
- AMIN1  out  4  alarm minute units.
- AMIN10  out  3  alarm minute tens.
- AHOUR1  out  4  alarm hour units.
- AHOUR10  out  2  alarm hour tens.
- ALMEN  out  1  alarm armed indicator.
- AMINON  out  1  alarm-minute display enable, active-high.
- AHOURON  out  1  alarm-hour display enable, active-high.
- BEEP  out  1  buzzer drive.
- ALMSET  out  1  high in either set state; display mux selects alarm time.

Behaviour:
- Reset: state IDLE, alarm time 00:00, ALMEN=0, tick counter 0, match register 0. Outputs at reset: BEEP=0, ALMSET=0, AMINON=1, AHOURON=1.
- States: IDLE, SETHOUR, SETMIN, RING, SNZ. All registered on CLK.
- IDLE:
  - ALMMODE -> SETHOUR.
  - Else armed trigger -> RING, counter cleared.
- SETHOUR/SETMIN:
  - ALMMODE -> IDLE.
  - Else SELECT toggles SETHOUR <-> SETMIN.
  - ADJUST increments the selected field in the same cycle it is sampled.
  - ADJUST and SELECT in the same cycle: increment the current field, then switch.
- Increment rules:
  - Hour: 00..23, 23 -> 00; 09 -> 10, 19 -> 20.
  - Minute: 00..59, 59 -> 00, no carry into hour.
  - BCD digits never take values > 9.
- Match: match = all four alarm digits equal the current digits.
  - match_q is a registered copy of match.
  - Armed trigger = ALMEN & match & ~match_q, evaluated only in IDLE: one trigger per minute entry.
  - Editing the alarm to the current time fires on return to IDLE only if match rises afterwards.
- RING: counter increments on SIG1HZ. Priority order:
  1. STOP -> IDLE.
  2. ALMSW -> IDLE; ALMEN clears.
  3. SNOOZE -> SNZ, counter cleared.
  4. Counter reaches RING_SEC-1 with SIG1HZ -> IDLE.
- SNZ: counter increments on SIG1HZ. Priority order:
  1. STOP or ALMSW -> IDLE; ALMSW also clears ALMEN.
  2. Counter reaches SNOOZE_SEC-1 with SIG1HZ -> RING, counter cleared.
- ALMMODE is ignored in RING and SNZ.
- ALMSW:
  - Toggles ALMEN in IDLE, SETHOUR and SETMIN.
  - In RING/SNZ it only clears ALMEN (never sets).
- Outputs, combinational from registered state:
  - BEEP = (state==RING) & SIG2HZ.
  - ALMSET = SETHOUR | SETMIN.
  - AHOURON = ~((state==SETHOUR) & SIG2HZ).
  - AMINON = ~((state==SETMIN) & SIG2HZ).
- Async RST mid-ring or mid-set returns to reset values on the next evaluation; no pending trigger is retained.

Decomposition:
- Shared package alarm_pkg: state encoding constants (IDLE=3'd0, SETHOUR=3'd1, SETMIN=3'd2, RING=3'd3, SNZ=3'd4), hour/minute limit constants (23, 59).
- One sub-module, alm_time_reg: holds the four BCD alarm digits, with inc_hour/inc_min inputs and wrap logic. The FSM, counter and match logic remain in alarm_ctrl.

Test Plan:
1. Reset, ALMMODE, ADJUST x25 -> AHOUR=01 (23->00 wrap seen); SELECT, ADJUST x61 -> AMIN=01; AHOURON blinks with SIG2HZ only in SETHOUR.
2. Alarm 07:30, ALMEN=1, time steps 07:29 -> 07:30 -> BEEP follows SIG2HZ next cycle; after 60 SIG1HZ pulses -> IDLE, BEEP=0, no re-trigger while time stays 07:30.
3. Ringing, SNOOZE -> BEEP=0; after 300 SIG1HZ pulses -> RING again; STOP -> IDLE, ALMEN still 1.
4. STOP and SNOOZE in the same cycle during RING -> IDLE (STOP wins); ALMSW during SNZ -> IDLE, ALMEN=0.
5. ALMEN=0, time reaches alarm -> no RING; ALMMODE coincident with a rising match in IDLE -> SETHOUR, no ring.
6. RST asserted mid-RING -> BEEP=0, alarm 00:00, ALMEN=0 immediately.
